// File: rtl/std_cache_bypass_arbiter_if.sv
// Bypass request/response types and the bundle connecting requesters, the
// arbiter and the downstream bypass adapter.
package std_cache_bypass_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
    logic [3:0]  amo_op;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] wdata;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;
endpackage

interface std_cache_bypass_if
  import std_cache_bypass_pkg::*;
#(
  parameter int unsigned NR_PORTS = 4
);
  bypass_req_t [NR_PORTS-1:0] req_i;
  bypass_rsp_t [NR_PORTS-1:0] rsp_o;
  bypass_req_t                req_o;
  bypass_rsp_t                rsp_i;

  // slave: the arbiter; master: requesters plus downstream adapter
  modport slave  (input  req_i, output rsp_o, output req_o, input  rsp_i);
  modport master (output req_i, input  rsp_o, input  req_o, output rsp_i);
endinterface

// File: rtl/std_cache_bypass_arbiter.sv
// Round-robin arbiter sharing the single uncached bypass port; one transaction
// in flight, response routed back to the owning requester.
module std_cache_bypass_arbiter
  import std_cache_bypass_pkg::*;
#(
  parameter int unsigned NR_PORTS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  std_cache_bypass_if.slave bus,
  output logic              busy_o
);
  localparam int unsigned LW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                     state_q, state_d;
  logic        [LW-1:0]       last_q, last_d;
  logic        [LW-1:0]       owner_q, owner_d;
  bypass_req_t                req_q, req_d;

  logic                       found;
  logic        [LW-1:0]       win;
  int unsigned                idx;
  bypass_rsp_t [NR_PORTS-1:0] rsp_o;
  bypass_req_t                req_o;

  // search ascends from the port after the last winner, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NR_PORTS; k++) begin
      idx = (int'(last_q) + k) % NR_PORTS;
      if (!found && bus.req_i[LW'(idx)].req) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    req_d   = req_q;
    rsp_o   = '0;
    req_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          rsp_o[win].gnt = 1'b1;
          req_d          = bus.req_i[win];
          // id carries the port index downstream, strobe is re-driven from state
          req_d.id       = 4'(win);
          req_d.req      = 1'b0;
          owner_d        = win;
          last_d         = win;
          state_d        = REQ;
        end
      end
      REQ: begin
        req_o     = req_q;
        req_o.req = 1'b1;
        if (bus.rsp_i.gnt) begin
          if (bus.rsp_i.valid) begin
            rsp_o[owner_q].valid = 1'b1;
            rsp_o[owner_q].rdata = bus.rsp_i.rdata;
            state_d              = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req_o = req_q;
        if (bus.rsp_i.valid) begin
          rsp_o[owner_q].valid = 1'b1;
          rsp_o[owner_q].rdata = bus.rsp_i.rdata;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= LW'(NR_PORTS - 1);
      owner_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  assign bus.rsp_o = rsp_o;
  assign bus.req_o = req_o;
  assign busy_o    = (state_q != IDLE);

  // a downstream valid with no granted request outstanding is dropped
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(bus.rsp_i.valid &&
                ((state_q == IDLE) || (state_q == REQ && !bus.rsp_i.gnt))))
        else $warning("spurious downstream valid ignored");
    end
  end
endmodule
